// File: rtl/rx_symbol_aligner.sv
// Word aligner between the deserializer and the PCS: finds K28.5 at any of the ten bit
// offsets, acquires symbol lock after repeated same-offset commas, and emits realigned symbols.
module rx_symbol_aligner #(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned UNLOCK_CNT = 4
) (
  input  logic       CLK,
  input  logic       Rst,
  input  logic [9:0] Data_in,
  input  logic       Data_valid,
  output logic [9:0] Data_out,
  output logic       Data_out_valid,
  output logic       Symbol_lock,
  output logic       Comma_det,
  output logic [3:0] Align_offset
);

  localparam logic [9:0] CommaNeg = 10'h0FA;
  localparam logic [9:0] CommaPos = 10'h305;
  localparam logic [2:0] LockTh   = 3'(LOCK_CNT);
  localparam logic [2:0] UnlockTh = 3'(UNLOCK_CNT);

  typedef enum logic [1:0] {StUnlocked, StCheck, StLocked} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  off_q, off_d;
  logic [9:0]  prev_q;
  logic        prev_ok_q;
  logic [9:0]  data_out_q;
  logic        data_out_valid_q;
  logic        symbol_lock_q;
  logic        comma_det_q;

  logic [19:0] window;
  logic [9:0]  cand [10];
  logic [9:0]  hits;
  logic        hit_any;
  logic        hit_cur;
  logic [3:0]  hit_k;
  logic [2:0]  cnt_inc;
  logic [9:0]  cand_next;
  logic        out_valid_d;

  // window[19] is the earliest bit; offset k selects window[19-k -: 10]
  assign window = {prev_q, Data_in};

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      cand[k] = 10'(window >> (10 - k));
      hits[k] = prev_ok_q && ((cand[k] == CommaNeg) || (cand[k] == CommaPos));
    end
  end

  // Scan downwards so the lowest matching offset wins
  always_comb begin
    hit_k = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (hits[k]) hit_k = 4'(k);
    end
  end

  assign hit_any = |hits;
  assign hit_cur = hits[off_q];
  assign cnt_inc = cnt_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    if (Data_valid) begin
      unique case (state_q)
        StUnlocked: begin
          if (hit_any) begin
            off_d = hit_k;
            if (LOCK_CNT == 1) begin
              state_d = StLocked;
              cnt_d   = 3'd0;
            end else begin
              state_d = StCheck;
              cnt_d   = 3'd1;
            end
          end
        end
        StCheck: begin
          if (hit_cur) begin
            if (cnt_inc == LockTh) begin
              state_d = StLocked;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (hit_any) begin
            off_d = hit_k;
            cnt_d = 3'd1;
          end
        end
        StLocked: begin
          // An aligned comma forgives any misaligned ones seen so far
          if (hit_cur) begin
            cnt_d = 3'd0;
          end else if (hit_any) begin
            if (cnt_inc == UnlockTh) begin
              state_d = StUnlocked;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: state_d = StUnlocked;
      endcase
    end
  end

  assign cand_next   = cand[off_d];
  assign out_valid_d = Data_valid && (state_d == StLocked);

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q          <= StUnlocked;
      cnt_q            <= 3'd0;
      off_q            <= 4'd0;
      prev_q           <= 10'd0;
      prev_ok_q        <= 1'b0;
      data_out_q       <= 10'd0;
      data_out_valid_q <= 1'b0;
      symbol_lock_q    <= 1'b0;
      comma_det_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      off_q            <= off_d;
      symbol_lock_q    <= (state_d == StLocked);
      data_out_valid_q <= out_valid_d;
      comma_det_q      <= out_valid_d && ((cand_next == CommaNeg) || (cand_next == CommaPos));
      if (Data_valid) begin
        prev_q     <= Data_in;
        prev_ok_q  <= 1'b1;
        data_out_q <= cand_next;
      end
    end
  end

  assign Data_out       = data_out_q;
  assign Data_out_valid = data_out_valid_q;
  assign Symbol_lock    = symbol_lock_q;
  assign Comma_det      = comma_det_q;
  assign Align_offset   = off_q;

endmodule
